// File: rtl/mem_access_ctrl_if.sv
// CPU-side request/response handshake of the memory access controller.
// The master drives requests; the slave (controller) answers with one-cycle response pulses.
interface mem_access_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Drives RAM port A for single CPU loads/stores; addr MSB selects the memory-mapped I/O pair
// (synchronized switch input, LED output register). One response pulse per request.
module mem_access_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    mem_access_ctrl_if.slave      cpu,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q,
    input  logic [DATA_WIDTH-1:0] io_in,
    output logic [DATA_WIDTH-1:0] io_out
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e                state_q, state_d;
    logic                  we_q, we_d;
    logic                  is_io_q, is_io_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;
    logic                  ram_we_q, ram_we_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [DATA_WIDTH-1:0] io_out_q, io_out_d;
    logic [DATA_WIDTH-1:0] io_sync1_q, io_sync1_d;
    logic [DATA_WIDTH-1:0] io_sync2_q, io_sync2_d;

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        is_io_d     = is_io_q;
        ram_addr_d  = ram_addr_q;
        ram_data_d  = ram_data_q;
        ram_we_d    = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        io_out_d    = io_out_q;
        io_sync1_d  = io_in;
        io_sync2_d  = io_sync1_q;

        unique case (state_q)
            IDLE: begin
                // Address/data are latched straight into the RAM-facing registers so they
                // are already stable for the whole ISSUE cycle; they double as the request copy.
                if (cpu.req_valid) begin
                    we_d       = cpu.req_we;
                    is_io_d    = cpu.req_addr[ADDR_WIDTH-1];
                    ram_addr_d = cpu.req_addr;
                    ram_data_d = cpu.req_wdata;
                    ram_we_d   = cpu.req_we & ~cpu.req_addr[ADDR_WIDTH-1];
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (is_io_q) begin
                    if (we_q) io_out_d    = ram_data_q;
                    else      rsp_rdata_d = io_sync2_q;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (we_q) begin
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                rsp_rdata_d = ram_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            is_io_q     <= 1'b0;
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
            ram_we_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            io_out_q    <= '0;
            io_sync1_q  <= '0;
            io_sync2_q  <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            is_io_q     <= is_io_d;
            ram_addr_q  <= ram_addr_d;
            ram_data_q  <= ram_data_d;
            ram_we_q    <= ram_we_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            io_out_q    <= io_out_d;
            io_sync1_q  <= io_sync1_d;
            io_sync2_q  <= io_sync2_d;
        end
    end

    // Gating with reset_n kills a store whose ISSUE cycle coincides with reset.
    assign ram_we        = ram_we_q & reset_n;
    assign ram_addr      = ram_addr_q;
    assign ram_data      = ram_data_q;
    assign io_out        = io_out_q;
    assign cpu.req_ready = (state_q == IDLE);
    assign cpu.rsp_valid = rsp_valid_q;
    assign cpu.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with a behavioural 1-cycle-latency RAM.
// Unwritten RAM words read back as 16'h5A00 ^ address.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  ram_addr;
    logic [15:0] ram_data;
    logic        ram_we;
    logic [15:0] ram_q;
    logic [15:0] io_in;
    logic [15:0] io_out;

    int checks = 0;
    int errors = 0;

    mem_access_ctrl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) bus ();

    mem_access_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cpu      (bus.slave),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_we   (ram_we),
        .ram_q    (ram_q),
        .io_in    (io_in),
        .io_out   (io_out)
    );

    always #5 clk = ~clk;

    logic [15:0]   mem [1024];
    logic [1023:0] wr = '0;

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_data;
            wr[ram_addr]  <= 1'b1;
        end
        ram_q <= wr[ram_addr] ? mem[ram_addr] : (16'h5A00 ^ {6'b0, ram_addr});
    end

    // Issues one request and observes cycles T+1..T+8 after the accept edge.
    task automatic do_req(input logic we, input logic [9:0] addr, input logic [15:0] wdata,
                          output logic [15:0] rdata, output int lat, output int we_cnt,
                          output int we_k, output int rsp_cnt);
        int guard;
        lat = 0; we_cnt = 0; we_k = 0; rsp_cnt = 0; rdata = '0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        guard = 0;
        while (bus.req_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (bus.req_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL accept_timeout addr=%h ready=%b required 1", addr, bus.req_ready);
        end
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) bus.req_valid = 1'b0;
            if (ram_we === 1'b1) begin
                we_cnt++;
                if (we_k == 0) we_k = k;
            end
            if (bus.rsp_valid === 1'b1) begin
                rsp_cnt++;
                if (lat == 0) begin
                    lat   = k;
                    rdata = bus.rsp_rdata;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 10'h005;
        bus.req_wdata = 16'hAAAA;
        io_in         = 16'h0000;
        repeat (3) begin
            @(negedge clk);
            checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.req_ready); end
            checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
            checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we got=%b exp=0", ram_we); end
            checks++; if (io_out !== 16'h0000) begin errors++; $display("FAIL reset_io_out got=%h exp=0000", io_out); end
        end
        checks++; if (bus.rsp_rdata !== 16'h0000) begin errors++; $display("FAIL reset_rsp_rdata got=%h exp=0000", bus.rsp_rdata); end
        checks++; if (ram_addr !== 10'h000) begin errors++; $display("FAIL reset_ram_addr got=%h exp=000", ram_addr); end
        bus.req_valid = 1'b0;
        reset_n       = 1'b1;
    endtask

    task automatic test_store_load();
        logic [15:0] rd;
        int lat, wc, wk, rc;
        do_req(1'b1, 10'h005, 16'h1234, rd, lat, wc, wk, rc);
        checks++; if (wc != 1) begin errors++; $display("FAIL store_we_count got=%0d exp=1", wc); end
        checks++; if (wk != 1) begin errors++; $display("FAIL store_we_cycle got=%0d exp=1", wk); end
        checks++; if (lat != 2) begin errors++; $display("FAIL store_latency got=%0d exp=2", lat); end
        checks++; if (rc != 1) begin errors++; $display("FAIL store_rsp_pulses got=%0d exp=1", rc); end
        do_req(1'b0, 10'h005, 16'h0000, rd, lat, wc, wk, rc);
        checks++; if (lat != 3) begin errors++; $display("FAIL load_latency got=%0d exp=3", lat); end
        checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL load_data got=%h exp=1234", rd); end
        checks++; if (wc != 0) begin errors++; $display("FAIL load_we_count got=%0d exp=0", wc); end
        checks++; if (rc != 1) begin errors++; $display("FAIL load_rsp_pulses got=%0d exp=1", rc); end
    endtask

    task automatic test_boundary();
        logic [15:0] rd;
        int lat, wc, wk, rc;
        do_req(1'b1, 10'h200, 16'hBEEF, rd, lat, wc, wk, rc);
        checks++; if (io_out !== 16'hBEEF) begin errors++; $display("FAIL io_store_out got=%h exp=beef", io_out); end
        checks++; if (wc != 0) begin errors++; $display("FAIL io_store_we got=%0d exp=0", wc); end
        checks++; if (lat != 2) begin errors++; $display("FAIL io_store_latency got=%0d exp=2", lat); end
        checks++; if (wr[10'h200] !== 1'b0) begin errors++; $display("FAIL io_store_ram_written got=%b exp=0", wr[10'h200]); end
        do_req(1'b0, 10'h1FF, 16'h0000, rd, lat, wc, wk, rc);
        checks++; if (rd !== 16'h5BFF) begin errors++; $display("FAIL bank_top_load got=%h exp=5bff", rd); end
        checks++; if (lat != 3) begin errors++; $display("FAIL bank_top_latency got=%0d exp=3", lat); end
    endtask

    task automatic test_io_load();
        logic [15:0] rd;
        int lat, wc, wk, rc;
        @(negedge clk);
        io_in = 16'h00A5;
        repeat (4) @(negedge clk);
        do_req(1'b0, 10'h3FF, 16'h0000, rd, lat, wc, wk, rc);
        checks++; if (lat != 2) begin errors++; $display("FAIL io_load_latency got=%0d exp=2", lat); end
        checks++; if (rd !== 16'h00A5) begin errors++; $display("FAIL io_load_data got=%h exp=00a5", rd); end
        checks++; if (wc != 0) begin errors++; $display("FAIL io_load_we got=%0d exp=0", wc); end
        checks++; if (io_out !== 16'hBEEF) begin errors++; $display("FAIL io_load_out_kept got=%h exp=beef", io_out); end
    endtask

    task automatic test_back_to_back();
        logic [9:0]  addrs [3];
        logic [15:0] exp_d [3];
        int acc [3];
        int n = 0, r = 0, ready_hi = 0;
        logic prev_rsp = 1'b0;
        addrs[0] = 10'h005; addrs[1] = 10'h006; addrs[2] = 10'h007;
        exp_d[0] = 16'h1234; exp_d[1] = 16'h5A06; exp_d[2] = 16'h5A07;
        bus.req_we = 1'b0;
        for (int cyc = 0; cyc < 18; cyc++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                checks++;
                if (prev_rsp) begin errors++; $display("FAIL b2b_pulse_width cyc=%0d rsp_valid high 2 cycles exp 1", cyc); end
                if (r < 3) begin
                    checks++;
                    if (bus.rsp_rdata !== exp_d[r]) begin errors++; $display("FAIL b2b_data%0d got=%h exp=%h", r, bus.rsp_rdata, exp_d[r]); end
                end
                r++;
            end
            prev_rsp = (bus.rsp_valid === 1'b1);
            bus.req_valid = (n < 3);
            bus.req_addr  = addrs[(n < 3) ? n : 2];
            if (bus.req_valid && bus.req_ready === 1'b1) begin
                ready_hi++;
                acc[n] = cyc;
                n++;
            end
        end
        bus.req_valid = 1'b0;
        checks++; if (n != 3) begin errors++; $display("FAIL b2b_accepts got=%0d exp=3", n); end
        checks++; if (ready_hi != 3) begin errors++; $display("FAIL b2b_ready_cycles got=%0d exp=3", ready_hi); end
        checks++; if (r != 3) begin errors++; $display("FAIL b2b_rsp_pulses got=%0d exp=3", r); end
        if (n == 3) begin
            checks++; if (acc[1] - acc[0] != 4) begin errors++; $display("FAIL b2b_spacing01 got=%0d exp=4", acc[1] - acc[0]); end
            checks++; if (acc[2] - acc[1] != 4) begin errors++; $display("FAIL b2b_spacing12 got=%0d exp=4", acc[2] - acc[1]); end
        end
    endtask

    task automatic test_reset_mid_op();
        logic [15:0] rd;
        int lat, wc, wk, rc;
        int rsp_seen = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 10'h010;
        bus.req_wdata = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        reset_n       = 1'b0;
        #1;
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL midrst_ram_we got=%b exp=0", ram_we); end
        @(negedge clk);
        if (bus.rsp_valid === 1'b1) rsp_seen++;
        reset_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) rsp_seen++;
        end
        checks++; if (rsp_seen != 0) begin errors++; $display("FAIL midrst_rsp got=%0d exp=0", rsp_seen); end
        checks++; if (wr[10'h010] !== 1'b0) begin errors++; $display("FAIL midrst_ram_written got=%b exp=0", wr[10'h010]); end
        checks++; if (io_out !== 16'h0000) begin errors++; $display("FAIL midrst_io_out got=%h exp=0000", io_out); end
        do_req(1'b0, 10'h010, 16'h0000, rd, lat, wc, wk, rc);
        checks++; if (rd !== 16'h5A10) begin errors++; $display("FAIL midrst_old_data got=%h exp=5a10", rd); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_load();
        test_boundary();
        test_io_load();
        test_back_to_back();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
